// File: rtl/riscv_pkg.sv
// Shared state encoding and default sizing for the instruction/data memory arbiter.
package riscv_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      DM_BUSY = 2'd2,
      DONE    = 2'd3
   } arb_state_e;

   // Counter width able to hold values 0..limit.
   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Fetch port, data port and shared bus port of the memory arbiter.
// The slave modport is the arbiter's view; master is the core/bus side.
interface riscv_mem_arbiter_if
   import riscv_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic                  iif_req;
   logic [ADDR_W-1:0]     iif_addr;
   logic [DATA_W-1:0]     oif_rdata;
   logic                  oif_ack;

   logic                  idm_req;
   logic                  idm_we;
   logic [DATA_W/8-1:0]   idm_be;
   logic [ADDR_W-1:0]     idm_addr;
   logic [DATA_W-1:0]     idm_wdata;
   logic [DATA_W-1:0]     odm_rdata;
   logic                  odm_ack;

   logic                  obus_req;
   logic                  obus_we;
   logic [DATA_W/8-1:0]   obus_be;
   logic [ADDR_W-1:0]     obus_addr;
   logic [DATA_W-1:0]     obus_wdata;
   logic                  ibus_ack;
   logic [DATA_W-1:0]     ibus_rdata;

   logic                  ostall_if;
   logic                  ostall_mem;
   logic                  oerr;

   modport slave (
      input  iif_req, iif_addr, idm_req, idm_we, idm_be, idm_addr, idm_wdata,
             ibus_ack, ibus_rdata,
      output oif_rdata, oif_ack, odm_rdata, odm_ack,
             obus_req, obus_we, obus_be, obus_addr, obus_wdata,
             ostall_if, ostall_mem, oerr
   );

   modport master (
      output iif_req, iif_addr, idm_req, idm_we, idm_be, idm_addr, idm_wdata,
             ibus_ack, ibus_rdata,
      input  oif_rdata, oif_ack, odm_rdata, odm_ack,
             obus_req, obus_we, obus_be, obus_addr, obus_wdata,
             ostall_if, ostall_mem, oerr
   );

endinterface

// File: rtl/riscv_timeout_counter.sv
// Bus wait counter: expired flags the TIMEOUT-th consecutive enabled cycle.
module riscv_timeout_counter
   import riscv_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
)(
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int               CNT_W = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear)
         count <= '0;
      else if (enable)
         count <= count + CNT_W'(1);
   end

   // Combinational so the abort lands on the same edge as a late ack would.
   assign expired = enable && (count == LAST);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one memory bus between instruction fetch and data access,
// data side first, with a bus wait timeout that aborts with oerr.
module riscv_mem_arbiter
   import riscv_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
)(
   input  logic               iclk,
   input  logic               irst,
   riscv_mem_arbiter_if.slave bus
);
   localparam int BE_W = DATA_W / 8;

   arb_state_e        state, state_nxt;
   logic              grant_dm, grant_if, finish, busy, expired;
   logic              req_q, we_q, if_ack_q, dm_ack_q, err_q;
   logic [BE_W-1:0]   be_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, if_rdata_q, dm_rdata_q, cap_rdata;

   always_ff @(posedge iclk) begin
      if (irst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Grants only from IDLE, so a request still held during DONE waits a cycle.
   always_comb begin
      state_nxt = state;
      grant_dm  = 1'b0;
      grant_if  = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.idm_req) begin
               grant_dm  = 1'b1;
               state_nxt = DM_BUSY;
            end else if (bus.iif_req) begin
               grant_if  = 1'b1;
               state_nxt = IF_BUSY;
            end
         end
         IF_BUSY, DM_BUSY: begin
            if (bus.ibus_ack || expired) begin
               finish    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == IF_BUSY) || (state == DM_BUSY);

   riscv_timeout_counter #(.TIMEOUT(TIMEOUT)) u_wait (
      .clk     (iclk),
      .rst     (irst),
      .clear   (grant_dm | grant_if),
      .enable  (busy & ~bus.ibus_ack),
      .expired (expired)
   );

   // An ack on the expiry cycle wins, so a timeout only ever captures zero.
   assign cap_rdata = bus.ibus_ack ? bus.ibus_rdata : '0;

   always_ff @(posedge iclk) begin
      if (irst) begin
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         be_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_ack_q   <= 1'b0;
         dm_ack_q   <= 1'b0;
         err_q      <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         if_ack_q <= 1'b0;
         dm_ack_q <= 1'b0;
         err_q    <= 1'b0;
         if (grant_dm) begin
            req_q   <= 1'b1;
            we_q    <= bus.idm_we;
            be_q    <= bus.idm_be;
            addr_q  <= bus.idm_addr;
            wdata_q <= bus.idm_wdata;
         end else if (grant_if) begin
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            be_q    <= '1;
            addr_q  <= bus.iif_addr;
            wdata_q <= '0;
         end
         if (finish) begin
            req_q <= 1'b0;
            err_q <= ~bus.ibus_ack;
            if (state == DM_BUSY) begin
               dm_ack_q   <= 1'b1;
               dm_rdata_q <= cap_rdata;
            end else begin
               if_ack_q   <= 1'b1;
               if_rdata_q <= cap_rdata;
            end
         end
      end
   end

   assign bus.obus_req   = req_q;
   assign bus.obus_we    = we_q;
   assign bus.obus_be    = be_q;
   assign bus.obus_addr  = addr_q;
   assign bus.obus_wdata = wdata_q;
   assign bus.oif_ack    = if_ack_q;
   assign bus.odm_ack    = dm_ack_q;
   assign bus.oif_rdata  = if_rdata_q;
   assign bus.odm_rdata  = dm_rdata_q;
   assign bus.oerr       = err_q;

   assign bus.ostall_if  = bus.iif_req & ~if_ack_q;
   assign bus.ostall_mem = bus.idm_req & ~dm_ack_q;

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, max bus wait cycles before abort.

REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- iclk  in  1  single clock, rising edge.
- irst  in  1  reset, synchronous, active-high.
- iif_req  in  1  fetch request, held until oif_ack.
- iif_addr  in  ADDR_W  fetch address.
- oif_rdata  out  DATA_W  fetch read data, valid with oif_ack.
- oif_ack  out  1  fetch done, 1-cycle pulse.
- idm_req  in  1  data request, held until odm_ack.
- idm_we  in  1  data write enable.
- idm_be  in  DATA_W/8  byte enables.
- idm_addr  in  ADDR_W  data address.
- idm_wdata  in  DATA_W  write data.
- odm_rdata  out  DATA_W  data read data, valid with odm_ack.
- odm_ack  out  1  data done, 1-cycle pulse.
- obus_req  out  1  bus request, held until ibus_ack or timeout.
- obus_we  out  1  bus write enable.
- obus_be  out  DATA_W/8  bus byte enables.
- obus_addr  out  ADDR_W  bus address.
- obus_wdata  out  DATA_W  bus write data.
- ibus_ack  in  1  bus completion.
- ibus_rdata  in  DATA_W  bus read data, valid with ibus_ack.
- ostall_if  out  1  stall request toward the hazard unit, fetch side.
- ostall_mem  out  1  stall request toward the hazard unit, memory side.
- oerr  out  1  timeout abort, 1-cycle pulse.

Function
REQ-003 FSM states SHALL be IDLE, IF_BUSY, DM_BUSY, DONE.
REQ-004 Arbitration SHALL happen only in IDLE, with fixed priority: data over fetch.
- idm_req goes to DM_BUSY; otherwise iif_req goes to IF_BUSY; otherwise stay IDLE.
REQ-005 On grant, the winner's addr/we/be/wdata SHALL be registered onto obus_*.
- obus_req asserts the cycle after the request is sampled.
- Fetch grants drive obus_we=0 and obus_be all-ones.
REQ-006 obus_* SHALL stay stable from assertion until the cycle ibus_ack is sampled high.
REQ-007 On ibus_ack in a BUSY state:
- ibus_rdata is captured and the FSM goes to DONE.
- obus_req deasserts the next cycle.
- In DONE the granted side's ack pulses for exactly one cycle; DONE then goes to IDLE.
REQ-008 No request SHALL be granted in DONE, so a request held through the ack cycle is never re-issued.
REQ-009 Latency:
- Request sampled at cycle N gives obus_req at N+1.
- ibus_ack at cycle M gives the requester's ack at M+1.
- Minimum N to ack is 2 cycles with a zero-wait bus.
REQ-010 Stall outputs SHALL be combinational:
- ostall_if = iif_req & ~oif_ack.
- ostall_mem = idm_req & ~odm_ack.
REQ-011 Timeout handling:
- A wait counter clears on grant and increments each BUSY cycle without ibus_ack.
- When the counter reaches TIMEOUT, obus_req drops, the FSM goes to DONE, rdata is forced to 0, and oerr pulses alongside the ack.
REQ-012 ibus_ack in the same cycle the counter reaches TIMEOUT SHALL be treated as success, with no oerr.
REQ-013 ibus_ack received in IDLE or DONE SHALL be ignored.
REQ-014 oif_rdata/odm_rdata SHALL hold their last captured value between acks.

Reset
REQ-015 While irst is high at a clock edge:
- FSM goes to IDLE and the wait counter clears.
- obus_req, oif_ack, odm_ack, oerr = 0.
- obus_*, oif_rdata, odm_rdata = 0.
REQ-016 Reset mid-transaction SHALL abandon it with no ack; the requester must re-request.

Structure
REQ-017 The FSM state enum and the default widths/TIMEOUT SHALL live in the shared package riscv_pkg.
REQ-018 The wait counter SHALL be a sub-module riscv_timeout_counter (clear, enable, expired outputs).

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Fetch only, addr 0x100, bus acks 1 cycle after obus_req with rdata 0xDEADBEEF -> oif_ack pulses once, oif_rdata=0xDEADBEEF, ostall_if high until the ack cycle.
- iif_req and idm_req rise the same cycle, data write 0x2000/0x12345678/be 0xF -> data bus cycle first (obus_we=1), then fetch granted after DONE; ostall_if stays high throughout.
- Bus inserts 5 wait states -> obus_addr/wdata stable all 5 cycles, ack at M+1, no oerr.
- No ibus_ack for TIMEOUT=4 cycles -> obus_req drops, odm_ack and oerr pulse together, odm_rdata=0.
- irst asserted in DM_BUSY -> next cycle obus_req=0 and FSM IDLE, no ack; a late ibus_ack is ignored.
- Back-to-back fetches with iif_req held through the ack -> exactly one bus transaction per ack.
